// File: rtl/alu_exec_stage.sv
// Execute stage: decodes alu_op/funct3/funct7, runs the op and registers the result with
// valid/ready on both sides. Define ALU_MUL_EN to add the iterative shift-add multiplier.
module alu_exec_stage #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned SERIAL_SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpXor, OpOr, OpAnd, OpNot, OpSll, OpSrl, OpSlt, OpMul, OpIll
  } op_e;

  typedef enum logic [1:0] {
    StIdle, StShift, StHold
`ifdef ALU_MUL_EN
    , StMul
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Holds the shifting operand in StShift and the partial product in StMul.
  logic [WIDTH-1:0] work_q, work_d;
  logic             shl_q, shl_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
`endif
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  op_e              f3_op, dec_op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] shift_nxt;
  logic             accept;
  logic             serial_shift;

  assign shamt     = operand_b[SHW-1:0];
  assign in_ready  = (state_q == StIdle) || ((state_q == StHold) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  always_comb begin
    f3_op = OpAdd;
    unique case (funct3)
      3'b000: f3_op = OpAdd;
      3'b001: f3_op = OpSll;
      3'b010: f3_op = OpSlt;
      3'b011: f3_op = OpNot;
      3'b100: f3_op = OpXor;
      3'b101: f3_op = OpSrl;
      3'b110: f3_op = OpOr;
      3'b111: f3_op = OpAnd;
      default: f3_op = OpAdd;
    endcase
  end

  always_comb begin
    dec_op = OpIll;
    unique case (alu_op)
      2'b00: begin
        if (funct7 == 7'b0000000) begin
          dec_op = f3_op;
        end else if ((funct7 == 7'b0100000) && (funct3 == 3'b000)) begin
          dec_op = OpSub;
`ifdef ALU_MUL_EN
        end else if ((funct7 == 7'b0000001) && (funct3 == 3'b000)) begin
          dec_op = OpMul;
`endif
        end
      end
      2'b01:   dec_op = f3_op;
      2'b10:   dec_op = OpAdd;
      default: dec_op = OpSub;
    endcase
  end

  // With SERIAL_SHIFT set, the single-cycle path only ever sees shamt == 0.
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OpAdd:   alu_res = operand_a + operand_b;
      OpSub:   alu_res = operand_a - operand_b;
      OpXor:   alu_res = operand_a ^ operand_b;
      OpOr:    alu_res = operand_a | operand_b;
      OpAnd:   alu_res = operand_a & operand_b;
      OpNot:   alu_res = ~operand_a;
      OpSll:   alu_res = (SERIAL_SHIFT != 0) ? operand_a : (operand_a << shamt);
      OpSrl:   alu_res = (SERIAL_SHIFT != 0) ? operand_a : (operand_a >> shamt);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      default: alu_res = '0;
    endcase
  end

  assign serial_shift = (SERIAL_SHIFT != 0) && ((dec_op == OpSll) || (dec_op == OpSrl)) &&
                        (shamt != '0);
  assign shift_nxt    = shl_q ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    shl_d       = shl_q;
`ifdef ALU_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
`endif
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;

    case (state_q)
      StIdle: ;
      StShift: begin
        work_d = shift_nxt;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = StHold;
          out_valid_d = 1'b1;
          result_d    = shift_nxt;
          zero_d      = (shift_nxt == '0);
          illegal_d   = 1'b0;
        end
      end
`ifdef ALU_MUL_EN
      StMul: begin
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        work_d   = work_q + (mplier_q[0] ? mcand_q : '0);
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = StHold;
          out_valid_d = 1'b1;
          result_d    = work_d;
          zero_d      = (work_d == '0);
          illegal_d   = 1'b0;
        end
      end
`endif
      StHold: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept overrides the HOLD drain so back-to-back transfers lose no cycle.
    if (accept) begin
      if (dec_op == OpIll) begin
        state_d     = StHold;
        out_valid_d = 1'b1;
        result_d    = '0;
        zero_d      = 1'b0;
        illegal_d   = 1'b1;
      end else if (serial_shift) begin
        state_d     = StShift;
        out_valid_d = 1'b0;
        cnt_d       = CW'(shamt);
        work_d      = operand_a;
        shl_d       = (dec_op == OpSll);
`ifdef ALU_MUL_EN
      end else if (dec_op == OpMul) begin
        state_d     = StMul;
        out_valid_d = 1'b0;
        cnt_d       = CW'(WIDTH);
        work_d      = '0;
        mcand_d     = operand_a;
        mplier_d    = operand_b;
`endif
      end else begin
        state_d     = StHold;
        out_valid_d = 1'b1;
        result_d    = alu_res;
        zero_d      = (alu_res == '0);
        illegal_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      work_q      <= '0;
      shl_q       <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
`endif
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      shl_q       <= shl_d;
`ifdef ALU_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
`endif
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (WIDTH=32, SERIAL_SHIFT=1).
module tb_alu_exec_stage;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   alu_op = '0;
  logic [2:0]   funct3 = '0;
  logic [6:0]   funct7 = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(
    .WIDTH        (W),
    .SERIAL_SHIFT (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .funct7    (funct7),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; presents one request across the next posedge.
  task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op    = op;
    funct3    = f3;
    funct7    = f7;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    #1;
    check({tag, " in_ready"}, W'(in_ready), W'(1));
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Latency counts posedges from the accepting edge up to out_valid.
  task automatic wait_out(input string tag, input int exp_lat);
    int lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, W'(lat), W'(exp_lat));
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] res, input logic z,
                            input logic ill);
    check({tag, " result"}, result, res);
    check({tag, " zero"}, W'(zero), W'(z));
    check({tag, " illegal"}, W'(illegal), W'(ill));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin : stim
    logic saw_valid;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst out_valid", W'(out_valid), W'(0));
    expect_out("rst", '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst in_ready", W'(in_ready), W'(1));

    // Add overflow wraps, single-cycle latency
    issue("add", 2'b00, 3'b000, 7'b0000000, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_out("add", 1);
    expect_out("add", 32'h8000_0000, 1'b0, 1'b0);
    consume();

    issue("beq", 2'b11, 3'b000, 7'b0000000, 32'd5, 32'd5);
    wait_out("beq", 1);
    expect_out("beq", 32'h0, 1'b1, 1'b0);
    consume();

    issue("sub", 2'b00, 3'b000, 7'b0100000, 32'd3, 32'd5);
    wait_out("sub", 1);
    expect_out("sub", 32'hFFFF_FFFE, 1'b0, 1'b0);
    consume();

    issue("slt", 2'b00, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'h1);
    wait_out("slt", 1);
    expect_out("slt", 32'h1, 1'b0, 1'b0);
    consume();

    issue("srl31", 2'b00, 3'b101, 7'b0000000, 32'h8000_0000, 32'd31);
    wait_out("srl31", 32);
    expect_out("srl31", 32'h1, 1'b0, 1'b0);
    consume();

    issue("slli0", 2'b01, 3'b001, 7'b0100000, 32'h0000_1234, 32'd0);
    wait_out("slli0", 1);
    expect_out("slli0", 32'h0000_1234, 1'b0, 1'b0);
    consume();

    // Inputs changed after accept must not leak into the in-flight shift
    issue("slli4", 2'b01, 3'b001, 7'b0000000, 32'h0000_1234, 32'd4);
    operand_a = 32'hFFFF_FFFF;
    operand_b = 32'd1;
    wait_out("slli4", 5);
    expect_out("slli4", 32'h0001_2340, 1'b0, 1'b0);
    consume();

    issue("xori", 2'b01, 3'b100, 7'b1111111, 32'h0000_F0F0, 32'h0000_FF00);
    wait_out("xori", 1);
    expect_out("xori", 32'h0000_0FF0, 1'b0, 1'b0);
    consume();

    issue("or", 2'b00, 3'b110, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00);
    wait_out("or", 1);
    expect_out("or", 32'h0000_FFF0, 1'b0, 1'b0);
    consume();

    issue("and", 2'b00, 3'b111, 7'b0000000, 32'h0000_F0F0, 32'h0000_FF00);
    wait_out("and", 1);
    expect_out("and", 32'h0000_F000, 1'b0, 1'b0);
    consume();

    issue("not", 2'b01, 3'b011, 7'b0000000, 32'h0, 32'h0);
    wait_out("not", 1);
    expect_out("not", 32'hFFFF_FFFF, 1'b0, 1'b0);
    consume();

    // Back-pressure in HOLD, then same-cycle accept on release
    issue("hold", 2'b10, 3'b000, 7'b0000000, 32'd1, 32'd2);
    wait_out("hold", 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold result", result, 32'd3);
      check("hold out_valid", W'(out_valid), W'(1));
      check("hold in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    alu_op    = 2'b10;
    operand_a = 32'd10;
    operand_b = 32'd20;
    in_valid  = 1'b1;
    #1;
    check("b2b in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b out_valid", W'(out_valid), W'(1));
    expect_out("b2b", 32'd30, 1'b0, 1'b0);
    consume();
    check("drain out_valid", W'(out_valid), W'(0));

    issue("ill", 2'b00, 3'b000, 7'b0000011, 32'd7, 32'd6);
    wait_out("ill", 1);
    expect_out("ill", 32'h0, 1'b0, 1'b1);
    consume();

`ifdef ALU_MUL_EN
    issue("mul", 2'b00, 3'b000, 7'b0000001, 32'd7, 32'd6);
    wait_out("mul", 33);
    expect_out("mul", 32'd42, 1'b0, 1'b0);
    consume();
`else
    issue("mul-off", 2'b00, 3'b000, 7'b0000001, 32'd7, 32'd6);
    wait_out("mul-off", 1);
    expect_out("mul-off", 32'h0, 1'b0, 1'b1);
    consume();
`endif

    // Leave a non-zero result registered, then reset in the middle of a shift
    issue("pre-rst", 2'b10, 3'b000, 7'b0000000, 32'd40, 32'd2);
    wait_out("pre-rst", 1);
    consume();
    issue("rst-shift", 2'b01, 3'b101, 7'b0000000, 32'hFFFF_FFFF, 32'd20);
    repeat (10) @(negedge clk);
    check("mid-shift out_valid", W'(out_valid), W'(0));
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", W'(out_valid), W'(0));
    expect_out("async rst", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("no stale out_valid", W'(saw_valid), W'(0));
    check("post-rst result", result, 32'h0);
    check("post-rst in_ready2", W'(in_ready), W'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
